dmem_bridge: RTL and testbench



---
 rtl/dmem_bridge.sv | 126 ++++++++++++
 tb/tb_dmem_bridge.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns each M-stage load/store into a req/ack bus
// transaction, stalls the pipeline until it completes, and flags misaligned or timed-out accesses.
module dmem_bridge #(
    parameter int          TIMEOUT = 16,
    parameter logic [31:0] ERRDATA = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memreadM,
    input  logic        memwriteM,
    input  logic        flushM,
    input  logic [31:0] aluoutM,
    input  logic [31:0] writedataM,
    output logic [31:0] readdataM,
    output logic        stallM,
    output logic        buserrM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic acc, aligned, is_load;

    assign acc     = (memreadM | memwriteM) & ~flushM;
    assign aligned = (aluoutM[1:0] == 2'b00);
    // A simultaneous read+write request is treated as a store.
    assign is_load = memreadM & ~memwriteM;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stallM  = 1'b0;
        buserrM = 1'b0;
        bus_req = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                stallM = acc & aligned;
                if (acc && aligned) begin
                    state_d = S_REQ;
                    addr_d  = {aluoutM[31:2], 2'b00};
                    wdata_d = writedataM;
                    we_d    = memwriteM;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end else if (acc) begin
                    buserrM = 1'b1;
                    if (is_load) rdata_d = ERRDATA;
                end
            end

            S_REQ: begin
                // M-stage inputs are ignored here; a started transaction always runs to the end.
                stallM  = 1'b1;
                bus_req = 1'b1;
                if (bus_ack) begin
                    if (!we_q) rdata_d = bus_rdata;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    err_d = 1'b1;
                    if (!we_q) rdata_d = ERRDATA;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DONE: begin
                // Pipeline advances on this edge; the same instruction must not restart.
                buserrM = err_q;
                state_d = S_IDLE;
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign readdataM = rdata_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: directed test-plan scenarios plus random
// accesses checked against a transaction-level model of stall, bus and read-data behaviour.
module tb_dmem_bridge;

    localparam int          TIMEOUT = 4;
    localparam logic [31:0] ERRDATA = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        memreadM, memwriteM, flushM;
    logic [31:0] aluoutM, writedataM, readdataM;
    logic        stallM, buserrM;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          last_ack_cyc = 0;
    logic [31:0] exp_rd;

    dmem_bridge #(.TIMEOUT(TIMEOUT), .ERRDATA(ERRDATA)) dut (
        .clk       (clk),
        .rst       (rst),
        .memreadM  (memreadM),
        .memwriteM (memwriteM),
        .flushM    (flushM),
        .aluoutM   (aluoutM),
        .writedataM(writedataM),
        .readdataM (readdataM),
        .stallM    (stallM),
        .buserrM   (buserrM),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one pipeline cycle with no M-stage access and checks the bridge is quiet.
    task automatic idle();
        tick();
        memreadM  = 1'b0;
        memwriteM = 1'b0;
        flushM    = 1'b0;
        bus_ack   = 1'($urandom_range(0, 1));
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL idle_req: got %b want 0", bus_req); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL idle_stall: got %b want 0", stallM); end
        checks++; if (buserrM !== 1'b0) begin errors++; $display("FAIL idle_err: got %b want 0", buserrM); end
        checks++; if (readdataM !== exp_rd) begin errors++; $display("FAIL idle_rdata: got %h want %h", readdataM, exp_rd); end
    endtask

    // One M-stage instruction. wait_n = number of REQ cycles before ack (>= TIMEOUT means never).
    // Ends in the DONE cycle with the instruction's inputs still applied.
    task automatic run_access(input logic rd, input logic wr, input logic fl,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int wait_n, input logic gap_chk);
        logic        acc, mis, tmo;
        logic [31:0] word;
        int          n_req;
        acc   = (rd | wr) & ~fl;
        mis   = acc & (addr[1:0] != 2'b00);
        tmo   = (wait_n >= TIMEOUT);
        n_req = tmo ? TIMEOUT : wait_n + 1;
        word  = {addr[31:2], 2'b00};

        tick();
        memreadM = rd; memwriteM = wr; flushM = fl; aluoutM = addr; writedataM = wdata;
        bus_ack  = 1'b0;
        bus_rdata = $urandom;
        #1;
        checks++; if (stallM !== (acc & ~mis)) begin errors++; $display("FAIL acc_stall: got %b want %b", stallM, acc & ~mis); end
        checks++; if (buserrM !== mis) begin errors++; $display("FAIL acc_err: got %b want %b", buserrM, mis); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL acc_req: got %b want 0", bus_req); end

        if (!acc || mis) begin
            if (mis && rd && !wr) exp_rd = ERRDATA;
            tick();
            memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0;
            #1;
            checks++; if (readdataM !== exp_rd) begin errors++; $display("FAIL nobus_rdata: got %h want %h", readdataM, exp_rd); end
            checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL nobus_req: got %b want 0", bus_req); end
            return;
        end

        for (int k = 0; k < n_req; k++) begin
            tick();
            bus_ack    = (k == wait_n);
            bus_rdata  = (k == wait_n) ? rdata : $urandom;
            flushM     = 1'($urandom_range(0, 1));
            aluoutM    = $urandom;
            writedataM = $urandom;
            #1;
            if (k == 0 && gap_chk) begin
                checks++;
                if (cyc - last_ack_cyc - 1 !== 2) begin errors++; $display("FAIL req_gap: got %0d want 2", cyc - last_ack_cyc - 1); end
            end
            checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL req_req: got %b want 1", bus_req); end
            checks++; if (stallM !== 1'b1) begin errors++; $display("FAIL req_stall: got %b want 1", stallM); end
            checks++; if (bus_we !== wr) begin errors++; $display("FAIL req_we: got %b want %b", bus_we, wr); end
            checks++; if (bus_addr !== word) begin errors++; $display("FAIL req_addr: got %h want %h", bus_addr, word); end
            checks++; if (bus_wdata !== wdata) begin errors++; $display("FAIL req_wdata: got %h want %h", bus_wdata, wdata); end
            checks++; if (buserrM !== 1'b0) begin errors++; $display("FAIL req_err: got %b want 0", buserrM); end
            if (k == wait_n) last_ack_cyc = cyc;
        end

        tick();
        memreadM = rd; memwriteM = wr; flushM = fl; aluoutM = addr; writedataM = wdata;
        bus_ack  = 1'($urandom_range(0, 1));
        #1;
        if (!wr) exp_rd = tmo ? ERRDATA : rdata;
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL done_stall: got %b want 0", stallM); end
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL done_req: got %b want 0", bus_req); end
        checks++; if (buserrM !== tmo) begin errors++; $display("FAIL done_err: got %b want %b", buserrM, tmo); end
        checks++; if (readdataM !== exp_rd) begin errors++; $display("FAIL done_rdata: got %h want %h", readdataM, exp_rd); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        memreadM = 1'b0; memwriteM = 1'b0; flushM = 1'b0;
        aluoutM = '0; writedataM = '0; bus_ack = 1'b0; bus_rdata = '0;
        exp_rd = '0;
        #3;
        checks++; if (readdataM !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", readdataM); end
        checks++; if (bus_req !== 1'b0 || stallM !== 1'b0 || buserrM !== 1'b0) begin
            errors++; $display("FAIL rst_ctrl: got req=%b stall=%b err=%b want 0", bus_req, stallM, buserrM); end
        checks++; if (bus_we !== 1'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_bus: got we=%b addr=%h wdata=%h want 0", bus_we, bus_addr, bus_wdata); end
        #4 rst = 1'b1;
    endtask

    task automatic test_zero_wait_load();
        run_access(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 32'hCAFE_F00D, 0, 1'b0);
        idle();
    endtask

    task automatic test_waited_store();
        run_access(1'b0, 1'b1, 1'b0, 32'h204, 32'h1234_5678, 32'h5555_AAAA, 3, 1'b0);
        idle();
    endtask

    task automatic test_timeout();
        run_access(1'b1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h0, 1000, 1'b0);
        idle();
    endtask

    task automatic test_misaligned_flush();
        run_access(1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h1111_1111, 1, 1'b0);
        run_access(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b1, 1'b0, 1'b0, 32'h14, 32'h0, 32'h2222_2222, 0, 1'b0);
        run_access(1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 0, 1'b0);
        run_access(1'b0, 1'b1, 1'b0, 32'h203, 32'h9999_9999, 32'h0, 0, 1'b0);
        run_access(1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 32'h0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_req();
        tick();
        memreadM = 1'b1; memwriteM = 1'b0; flushM = 1'b0; aluoutM = 32'h40; bus_ack = 1'b0;
        tick();
        #1;
        checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL mid_req_up: got %b want 1", bus_req); end
        #2;
        rst = 1'b0;
        memreadM = 1'b0;
        exp_rd = '0;
        #1;
        checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %b want 0", bus_req); end
        checks++; if (stallM !== 1'b0) begin errors++; $display("FAIL mid_rst_stall: got %b want 0", stallM); end
        checks++; if (readdataM !== 32'h0) begin errors++; $display("FAIL mid_rst_rdata: got %h want 0", readdataM); end
        #2 rst = 1'b1;
        idle();
        run_access(1'b1, 1'b1, 1'b0, 32'h80, 32'hA5A5_5A5A, 32'h0, 1, 1'b0);
        idle();
    endtask

    task automatic test_back_to_back();
        run_access(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0BAD_CAFE, 0, 1'b0);
        run_access(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h7777_0001, 0, 1'b1);
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            logic        rd, wr, fl;
            logic [31:0] addr;
            rd   = 1'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            fl   = ($urandom_range(0, 3) == 0);
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            run_access(rd, wr, fl, addr, $urandom, $urandom, $urandom_range(0, TIMEOUT + 1), 1'b0);
            if ($urandom_range(0, 1) == 0) idle();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_zero_wait_load();
        test_waited_store();
        test_timeout();
        test_misaligned_flush();
        test_reset_mid_req();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
